// File: rtl/nios2_debug_pkg.sv
// Shared definitions for the Nios II debug-slave sysclk logic: jdo field
// offsets and the decoded OCI memory command.
package nios2_debug_pkg;

  localparam int JDO_W         = 38;
  localparam int JDO_WDATA_LSB = 3;
  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_RD_BIT    = 35;

  typedef enum logic [2:0] {
    OCIMEM_IDLE,     // no command this cycle
    OCIMEM_LOAD,     // load MonAReg only
    OCIMEM_LOAD_RD,  // load MonAReg and read the new address
    OCIMEM_NEXT_RD,  // increment MonAReg and read the new address
    OCIMEM_WRITE     // write at MonAReg, then increment
  } ocimem_cmd_e;

  // Turns the one-hot take_* strobes into a single command.
  function automatic ocimem_cmd_e ocimem_decode(input logic act_a,
                                                input logic no_act_a,
                                                input logic act_b,
                                                input logic rd_flag);
    ocimem_cmd_e cmd;
    cmd = OCIMEM_IDLE;
    if (act_b)         cmd = OCIMEM_WRITE;
    else if (no_act_a) cmd = OCIMEM_NEXT_RD;
    else if (act_a)    cmd = rd_flag ? OCIMEM_LOAD_RD : OCIMEM_LOAD;
    return cmd;
  endfunction

endpackage

// File: rtl/nios2_debug_ocimem_ram.sv
// Single-port, byte-enabled OCI RAM. Two-cycle read: the address is
// registered, then the array output is registered. Writes land on the
// access edge, so a read issued in the following cycle sees the new data.
module nios2_debug_ocimem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr_q;

  // Byte-lane masked write.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Registered address followed by registered array output.
  always_ff @(posedge clk) begin
    addr_q <= addr;
    rdata  <= mem[addr_q];
  end

endmodule

// File: rtl/nios2_debug_ocimem_ctrl.sv
// Sysclk-side OCI memory controller: decodes the debug-slave strobes,
// owns MonAReg/MonDReg, and shares the OCI RAM with a CPU slave port.
//
// CPU handshake: a request (cpu_read or cpu_write) is accepted in any cycle
// where it is asserted and cpu_waitrequest is low; while cpu_waitrequest is
// high the master holds address, data and qualifiers unchanged. Each accepted
// read returns exactly one cpu_readdatavalid pulse RD_LAT cycles later, in
// order. JTAG strobes are never stalled and take the RAM in their own cycle.
module nios2_debug_ocimem_ctrl
  import nios2_debug_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [JDO_W-1:0]    jdo,
  input  logic                take_action_ocimem_a,
  input  logic                take_no_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  output logic [DATA_W-1:0]   MonDReg,
  output logic                mon_busy,
  input  logic [ADDR_W-1:0]   cpu_address,
  input  logic                cpu_read,
  input  logic                cpu_write,
  input  logic [DATA_W-1:0]   cpu_writedata,
  input  logic [DATA_W/8-1:0] cpu_byteenable,
  output logic                cpu_waitrequest,
  output logic [DATA_W-1:0]   cpu_readdata,
  output logic                cpu_readdatavalid
);

  ocimem_cmd_e         cmd;
  logic [ADDR_W-1:0]   mon_a_reg;
  logic [ADDR_W-1:0]   next_addr;
  logic [ADDR_W-1:0]   jdo_addr;
  logic [DATA_W-1:0]   jdo_wdata;
  logic [DATA_W-1:0]   mon_d_reg;
  logic                jtag_rd;
  logic                jtag_wr;
  logic                jtag_access;
  logic                cpu_accept;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W/8-1:0] ram_be;
  logic [DATA_W-1:0]   ram_rdata;
  logic [RD_LAT-1:0]   jtag_tag;
  logic [RD_LAT-1:0]   cpu_tag;
  logic                jdo_unused;

  // Reset dominates: no command is acted on while reset is high.
  assign cmd = reset ? OCIMEM_IDLE
                     : ocimem_decode(take_action_ocimem_a, take_no_action_ocimem_a,
                                     take_action_ocimem_b, jdo[JDO_RD_BIT]);

  assign jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign jdo_wdata  = jdo[JDO_WDATA_LSB +: DATA_W];
  assign jdo_unused = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_WDATA_LSB-1:0]};
  assign next_addr  = mon_a_reg + ADDR_W'(1);

  assign jtag_rd     = (cmd == OCIMEM_LOAD_RD) || (cmd == OCIMEM_NEXT_RD);
  assign jtag_wr     = (cmd == OCIMEM_WRITE);
  assign jtag_access = jtag_rd || jtag_wr;

  // CPU is stalled in reset and in any cycle a JTAG access owns the RAM.
  assign cpu_waitrequest = reset || jtag_access;
  assign cpu_accept      = (cpu_read || cpu_write) && !cpu_waitrequest;

  // RAM port mux: JTAG access wins, otherwise the accepted CPU request.
  always_comb begin
    ram_addr  = cpu_address;
    ram_wdata = cpu_writedata;
    ram_be    = cpu_byteenable;
    ram_we    = cpu_write && cpu_accept;
    case (cmd)
      OCIMEM_LOAD_RD: begin
        ram_addr = jdo_addr;
        ram_we   = 1'b0;
      end
      OCIMEM_NEXT_RD: begin
        ram_addr = next_addr;
        ram_we   = 1'b0;
      end
      OCIMEM_WRITE: begin
        ram_addr  = mon_a_reg;
        ram_wdata = jdo_wdata;
        ram_be    = '1;
        ram_we    = 1'b1;
      end
      default: ;
    endcase
  end

  nios2_debug_ocimem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .be    (ram_be),
    .rdata (ram_rdata)
  );

  // JTAG word address: load, or post-increment after next-read and write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mon_a_reg <= '0;
    end else begin
      case (cmd)
        OCIMEM_LOAD, OCIMEM_LOAD_RD: mon_a_reg <= jdo_addr;
        OCIMEM_NEXT_RD, OCIMEM_WRITE: mon_a_reg <= next_addr;
        default: ;
      endcase
    end
  end

  // Read tags follow each RAM read so its data reaches the right requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      jtag_tag <= '0;
      cpu_tag  <= '0;
    end else begin
      jtag_tag <= {jtag_tag[RD_LAT-2:0], jtag_rd};
      cpu_tag  <= {cpu_tag[RD_LAT-2:0], cpu_read && cpu_accept};
    end
  end

  // MonDReg captures RAM data when a JTAG tag reaches the end of the pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      mon_d_reg <= '0;
    end else if (jtag_tag[RD_LAT-1]) begin
      mon_d_reg <= ram_rdata;
    end
  end

  assign MonDReg           = mon_d_reg;
  assign mon_busy          = (|jtag_tag) && !reset;
  assign cpu_readdatavalid = cpu_tag[RD_LAT-1] && !reset;
  assign cpu_readdata      = cpu_readdatavalid ? ram_rdata : '0;

  // Only one debug-slave command may be strobed per cycle.
  a_one_strobe: assert property (@(posedge clk) disable iff (reset)
    $onehot0({take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b}))
    else $error("more than one take_* strobe in one cycle");

endmodule

// File: tb/tb_nios2_debug_ocimem_ctrl.sv
// Directed bench for nios2_debug_ocimem_ctrl. Drivers push expected read
// data and arrival cycle into queues; a negedge monitor pops and compares.
module tb_nios2_debug_ocimem_ctrl;

  logic        clk;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [31:0] MonDReg;
  logic        mon_busy;
  logic [7:0]  cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic        cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic        cpu_readdatavalid;

  int check_cnt = 0;
  int fail_cnt  = 0;
  int cyc       = 0;
  logic mon_busy_prev = 1'b0;

  logic [31:0] cpu_exp_q[$];
  int          cpu_cyc_q[$];
  logic [31:0] mon_exp_q[$];
  int          mon_cyc_q[$];

  nios2_debug_ocimem_ctrl dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .MonDReg                 (MonDReg),
    .mon_busy                (mon_busy),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_write               (cpu_write),
    .cpu_writedata           (cpu_writedata),
    .cpu_byteenable          (cpu_byteenable),
    .cpu_waitrequest         (cpu_waitrequest),
    .cpu_readdata            (cpu_readdata),
    .cpu_readdatavalid       (cpu_readdatavalid)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every CPU read return and every MonDReg update.
  always @(negedge clk) begin
    if (cpu_readdatavalid === 1'b1) begin
      if (cpu_exp_q.size() == 0) begin
        check_cnt++;
        fail_cnt++;
        $display("FAIL cpu_unexpected_valid: got readdata %h with nothing expected (cycle %0d)",
                 cpu_readdata, cyc);
      end else begin
        check("cpu_readdata", cpu_readdata, cpu_exp_q.pop_front());
        check("cpu_valid_cycle", cyc, cpu_cyc_q.pop_front());
      end
    end
    if (mon_busy_prev && (mon_busy === 1'b0)) begin
      if (mon_exp_q.size() == 0) begin
        check_cnt++;
        fail_cnt++;
        $display("FAIL mon_unexpected_update: got MonDReg %h with nothing expected (cycle %0d)",
                 MonDReg, cyc);
      end else begin
        check("MonDReg", MonDReg, mon_exp_q.pop_front());
        check("mon_done_cycle", cyc, mon_cyc_q.pop_front());
      end
    end
    mon_busy_prev <= (mon_busy === 1'b1);
  end

  // JTAG drivers: strobe for one cycle plus idle spacing.
  task automatic jtag_write(input logic [31:0] wdata);
    jdo = '0;
    jdo[34:3] = wdata;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    tick();
  endtask

  task automatic jtag_load(input logic [7:0] addr, input logic rd, input logic [31:0] exp);
    jdo = '0;
    jdo[24:17] = addr;
    jdo[35] = rd;
    take_action_ocimem_a = 1'b1;
    if (rd) begin
      mon_exp_q.push_back(exp);
      mon_cyc_q.push_back(cyc + 3);
    end
    tick();
    take_action_ocimem_a = 1'b0;
    tick();
    if (rd) tick();
  endtask

  task automatic jtag_next(input logic [31:0] exp);
    take_no_action_ocimem_a = 1'b1;
    mon_exp_q.push_back(exp);
    mon_cyc_q.push_back(cyc + 3);
    tick();
    take_no_action_ocimem_a = 1'b0;
    tick();
    tick();
  endtask

  // CPU drivers: hold the request until accepted (bounded).
  task automatic wait_accept(input string name, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while ((cpu_waitrequest !== 1'b0) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    acc_cyc = cyc;
    if (cpu_waitrequest !== 1'b0) begin
      check_cnt++;
      fail_cnt++;
      $display("FAIL %s: got waitrequest %b after 20 cycles, expected 0", name, cpu_waitrequest);
    end
    tick();
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    int acc;
    cpu_address = a;
    cpu_writedata = d;
    cpu_byteenable = be;
    cpu_read = 1'b0;
    cpu_write = 1'b1;
    wait_accept("cpu_wr_accept", acc);
  endtask

  task automatic cpu_rd(input logic [7:0] a, input logic [31:0] exp);
    int acc;
    cpu_address = a;
    cpu_write = 1'b0;
    cpu_read = 1'b1;
    wait_accept("cpu_rd_accept", acc);
    cpu_exp_q.push_back(exp);
    cpu_cyc_q.push_back(acc + 2);
  endtask

  task automatic cpu_idle();
    cpu_read = 1'b0;
    cpu_write = 1'b0;
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Stimulus.
  initial begin
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    cpu_address = '0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_writedata = '0;
    cpu_byteenable = '0;

    // Reset state.
    tick(); tick(); tick();
    @(negedge clk);
    check("rst_waitrequest", cpu_waitrequest, 1);
    check("rst_MonDReg", MonDReg, 0);
    check("rst_mon_busy", mon_busy, 0);
    check("rst_readdatavalid", cpu_readdatavalid, 0);
    check("rst_readdata", cpu_readdata, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("idle_waitrequest", cpu_waitrequest, 0);
    tick();

    // Writes at MonAReg=0 then 1 (auto-increment).
    jtag_write(32'hDEADBEEF);
    jtag_write(32'h11111111);

    // Load+read, then read-next.
    jtag_load(8'h00, 1'b1, 32'hDEADBEEF);
    jtag_next(32'h11111111);

    // Load without read, then write there.
    jtag_load(8'h05, 1'b0, 32'h0);
    jtag_write(32'h55555555);

    // Address wrap on write and on read-next.
    jtag_load(8'hFF, 1'b0, 32'h0);
    jtag_write(32'hCAFEF00D);
    jtag_next(32'h11111111);
    jtag_load(8'hFF, 1'b1, 32'hCAFEF00D);
    jtag_next(32'hDEADBEEF);

    // CPU write coincident with a JTAG write.
    jtag_load(8'h20, 1'b0, 32'h0);
    jdo = '0;
    jdo[34:3] = 32'h20202020;
    take_action_ocimem_b = 1'b1;
    cpu_address = 8'h10;
    cpu_writedata = 32'h10101010;
    cpu_byteenable = 4'hF;
    cpu_write = 1'b1;
    @(negedge clk);
    check("wait_coincident", cpu_waitrequest, 1);
    tick();
    take_action_ocimem_b = 1'b0;
    @(negedge clk);
    check("wait_next_free", cpu_waitrequest, 0);
    tick();
    cpu_idle();
    tick();
    cpu_rd(8'h20, 32'h20202020);
    cpu_rd(8'h10, 32'h10101010);
    cpu_idle();
    tick();

    // Byte-lane write followed immediately by a read of the same word.
    cpu_wr(8'h10, 32'hFFFFFFFF, 4'b0101);
    cpu_rd(8'h10, 32'h10FF10FF);
    cpu_idle();
    tick();

    // Back-to-back pipelined CPU reads.
    cpu_rd(8'h00, 32'hDEADBEEF);
    cpu_rd(8'h01, 32'h11111111);
    cpu_rd(8'h05, 32'h55555555);
    cpu_idle();
    tick(); tick();

    // JTAG read with CPU reads overlapping in the pipeline.
    jdo = '0;
    jdo[24:17] = 8'h01;
    jdo[35] = 1'b1;
    take_action_ocimem_a = 1'b1;
    mon_exp_q.push_back(32'h11111111);
    mon_cyc_q.push_back(cyc + 3);
    tick();
    take_action_ocimem_a = 1'b0;
    cpu_rd(8'h05, 32'h55555555);
    cpu_rd(8'hFF, 32'hCAFEF00D);
    cpu_idle();
    tick(); tick(); tick();

    // Reset one cycle after a JTAG read strobe, with a CPU read in flight.
    cpu_address = 8'h00;
    cpu_read = 1'b1;
    tick();
    cpu_idle();
    jdo = '0;
    jdo[24:17] = 8'h00;
    jdo[35] = 1'b1;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", mon_busy, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_MonDReg", MonDReg, 0);
      check("post_rst_busy", mon_busy, 0);
      tick();
    end

    // RAM contents survive reset; JTAG works again.
    cpu_rd(8'h00, 32'hDEADBEEF);
    cpu_idle();
    tick();
    jtag_load(8'h01, 1'b1, 32'h11111111);

    // Drain and confirm nothing is left outstanding.
    for (int i = 0; i < 20; i++) begin
      if ((cpu_exp_q.size() == 0) && (mon_exp_q.size() == 0)) break;
      tick();
    end
    check("cpu_q_drained", cpu_exp_q.size(), 0);
    check("mon_q_drained", mon_exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
    $finish;
  end

endmodule
